// File: rtl/quickq_client_if.sv
// Producer-facing command/response channels of the QuickQ client.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both 1;
// a source raising valid keeps valid and its payload unchanged until that edge.
interface quickq_client_if #(
  parameter int W = 32
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/quickq_client.sv
// Host-side requester for the QuickQ priority-queue core: one push/pop in flight,
// local full/empty rejection, busy-edge completion detection and a bounded wait.
module quickq_client #(
  parameter int W       = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  quickq_client_if.slave cmd_if,
  output logic          q_enq,
  output logic          q_deq,
  output logic [W-1:0]  q_data,
  input  logic          q_busy,
  input  logic [W-1:0]  q_rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic [1:0]    state_dbg
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          op_q;
  logic [TW-1:0] timer;
  logic          seen_busy;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rsp_data_q;
  logic          rsp_err_q;

  logic accept;
  logic reject;
  logic done;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign accept = cmd_if.cmd_valid & cmd_if.cmd_ready;
  assign reject = accept & ((~cmd_if.cmd_op & full) | (cmd_if.cmd_op & empty));
  // Completion needs a busy phase first, so a core that is slow to start is not mistaken for done.
  assign done   = seen_busy & ~q_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= 1'b0;
      q_data     <= '0;
      timer      <= '0;
      seen_busy  <= 1'b0;
      cnt        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (reject) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state      <= S_RESP;
          end else if (accept) begin
            op_q   <= cmd_if.cmd_op;
            q_data <= cmd_if.cmd_data;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer     <= '0;
          seen_busy <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (q_busy) seen_busy <= 1'b1;
          if (done) begin
            rsp_data_q <= op_q ? q_rdata : '0;
            rsp_err_q  <= 1'b0;
            cnt        <= op_q ? (cnt - 1'b1) : (cnt + 1'b1);
            state      <= S_RESP;
          end else if (timer == T_LAST) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (cmd_if.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pulses decode straight from state so they drop the instant reset asserts.
  assign q_enq            = (state == S_ISSUE) & ~op_q;
  assign q_deq            = (state == S_ISSUE) &  op_q;
  assign cmd_if.cmd_ready = (state == S_IDLE) & rst_n;
  assign cmd_if.rsp_valid = (state == S_RESP);
  assign cmd_if.rsp_data  = rsp_data_q;
  assign cmd_if.rsp_err   = rsp_err_q;
  assign count            = cnt;
  assign state_dbg        = state;
endmodule
